// File: rtl/result_requant_wb_pkg.sv
// Shared types and constants for the result requantisation / writeback block.
package result_requant_wb_pkg;

  // Writeback job controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LANES      = 32;   // result lanes per vector
  localparam int PSUM_BW    = 24;   // signed partial-sum width per lane
  localparam int DATA_W     = 8;    // signed output width per lane
  localparam int SAT_MAX    = 127;  // upper output clamp
  localparam int SAT_MIN    = -128; // lower output clamp
  localparam int MAX_JOB    = 64;   // longest job in vectors
  localparam int NUM_VEC_BW = 7;    // holds 0..MAX_JOB
  localparam int SHIFT_BW   = 5;    // holds 0..PSUM_BW-1

endpackage

// File: rtl/result_requant_wb_lane.sv
// One requantisation lane: ReLU, round-half-up offset, arithmetic shift
// (registered), then saturation to the signed output width.
module requant_lane
  import result_requant_wb_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = PSUM_BW,
  parameter int DATA_BW        = DATA_W
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             relu_en,
  input  logic [SHIFT_BW-1:0]              shift,
  input  logic signed [PARTIAL_SUM_BW-1:0] x,
  output logic signed [DATA_BW-1:0]        q
);

  // One extra bit so the rounding add can never overflow.
  localparam int EXT_BW = PARTIAL_SUM_BW + 1;
  localparam logic signed [EXT_BW-1:0] SAT_HI = EXT_BW'((1 <<< (DATA_BW - 1)) - 1);
  localparam logic signed [EXT_BW-1:0] SAT_LO = ~SAT_HI;

  logic signed [EXT_BW-1:0] r_s;
  logic signed [EXT_BW-1:0] ofs_s;
  logic signed [EXT_BW-1:0] sum_s;
  logic signed [EXT_BW-1:0] y_r;

  // Stage 1 combinational: clamp negatives when ReLU is on, add half an LSB of the shifted result.
  always_comb begin
    r_s   = '0;
    ofs_s = '0;
    if (relu_en && x[PARTIAL_SUM_BW-1]) begin
      r_s = '0;
    end else begin
      r_s = {x[PARTIAL_SUM_BW-1], x};
    end
    if (shift != {SHIFT_BW{1'b0}}) begin
      ofs_s = {{(EXT_BW-1){1'b0}}, 1'b1} << (shift - 5'd1);
    end else begin
      ofs_s = '0;
    end
    sum_s = r_s + ofs_s;
  end

  // Stage 1 register: arithmetic right shift of the rounded sum.
  always_ff @(posedge clk) begin
    if (rstn) begin
      y_r <= '0;
    end else begin
      y_r <= sum_s >>> shift;
    end
  end

  // Stage 2 combinational: clamp to the signed output range.
  always_comb begin
    q = '0;
    if (y_r > SAT_HI) begin
      q = SAT_HI[DATA_BW-1:0];
    end else if (y_r < SAT_LO) begin
      q = SAT_LO[DATA_BW-1:0];
    end else begin
      q = y_r[DATA_BW-1:0];
    end
  end

endmodule

// File: rtl/result_requant_wb.sv
// Requantises MATRIX_SIZE-lane partial-sum vectors to DATA_BW and writes them
// to consecutive unified-buffer addresses. A job is launched by start and
// finishes with a one-cycle done pulse after its last write.
module result_requant_wb
  import result_requant_wb_pkg::*;
#(
  parameter int MATRIX_SIZE    = LANES,
  parameter int PARTIAL_SUM_BW = PSUM_BW,
  parameter int DATA_BW        = DATA_W,
  parameter int ADDRESSSIZE    = 10
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [ADDRESSSIZE-1:0]              base_addr,
  input  logic [NUM_VEC_BW-1:0]               num_vec,
  input  logic [SHIFT_BW-1:0]                 shift,
  input  logic                                relu_en,
  input  logic                                in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                                wr_en,
  output logic [ADDRESSSIZE-1:0]              wr_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]      wr_data,
  output logic                                busy,
  output logic                                done,
  output logic                                overrun
);

  state_e                               state_r;
  state_e                               state_next_s;
  logic                                 accept_s;
  logic                                 launch_s;

  logic [ADDRESSSIZE-1:0]               base_r;
  logic [NUM_VEC_BW-1:0]                num_vec_r;
  logic [SHIFT_BW-1:0]                  shift_r;
  logic                                 relu_r;
  logic [NUM_VEC_BW-1:0]                in_cnt_r;
  logic                                 overrun_r;

  logic                                 v0_r;
  logic [ADDRESSSIZE-1:0]               addr0_r;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] data0_r;
  logic                                 v1_r;
  logic [ADDRESSSIZE-1:0]               addr1_r;
  logic [DATA_BW*MATRIX_SIZE-1:0]       lane_q_s;

  logic                                 wr_en_r;
  logic [ADDRESSSIZE-1:0]               wr_addr_r;
  logic [DATA_BW*MATRIX_SIZE-1:0]       wr_data_r;
  logic                                 busy_r;
  logic                                 done_r;

  // Next-state logic; FLUSH waits only for entries that have not yet reached the write register.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    launch_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          launch_s = 1'b1;
          if (num_vec == {NUM_VEC_BW{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if ((in_cnt_r + 7'd1) == num_vec_r) begin
            state_next_s = ST_FLUSH;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!v0_r && !v1_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Job configuration and accepted-vector counter, captured on an accepted start.
  always_ff @(posedge clk) begin
    if (rstn) begin
      base_r    <= '0;
      num_vec_r <= '0;
      shift_r   <= '0;
      relu_r    <= 1'b0;
      in_cnt_r  <= '0;
    end else if (launch_s) begin
      base_r    <= base_addr;
      num_vec_r <= num_vec;
      shift_r   <= shift;
      relu_r    <= relu_en;
      in_cnt_r  <= '0;
    end else if (accept_s) begin
      in_cnt_r  <= in_cnt_r + 7'd1;
    end else begin
      in_cnt_r  <= in_cnt_r;
    end
  end

  // Sticky overrun: a vector arriving outside RUN is dropped; a launch clears the flag.
  always_ff @(posedge clk) begin
    if (rstn) begin
      overrun_r <= 1'b0;
    end else if (in_valid && (state_r != ST_RUN)) begin
      overrun_r <= 1'b1;
    end else if (launch_s) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Capture stage: hold the accepted vector and its target address.
  always_ff @(posedge clk) begin
    if (rstn) begin
      v0_r    <= 1'b0;
      addr0_r <= '0;
      data0_r <= '0;
    end else if (accept_s) begin
      v0_r    <= 1'b1;
      addr0_r <= base_r + ADDRESSSIZE'(in_cnt_r);
      data0_r <= in_data;
    end else begin
      v0_r    <= 1'b0;
      addr0_r <= addr0_r;
      data0_r <= data0_r;
    end
  end

  // Valid/address travel alongside the lane stage-1 registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      v1_r    <= 1'b0;
      addr1_r <= '0;
    end else begin
      v1_r    <= v0_r;
      addr1_r <= addr0_r;
    end
  end

  genvar g;
  generate
    for (g = 0; g < MATRIX_SIZE; g++) begin : g_lane
      requant_lane #(
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .DATA_BW        (DATA_BW)
      ) u_lane (
        .clk     (clk),
        .rstn    (rstn),
        .relu_en (relu_r),
        .shift   (shift_r),
        .x       (data0_r[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
        .q       (lane_q_s[g*DATA_BW +: DATA_BW])
      );
    end
  endgenerate

  // Write register: address and data forced to zero whenever no write is issued.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else if (v1_r) begin
      wr_en_r   <= 1'b1;
      wr_addr_r <= addr1_r;
      wr_data_r <= lane_q_s;
    end else begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end
  end

  // Status outputs registered in step with the state register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_result_requant_wb.sv
// Self-checking bench for result_requant_wb: directed scenarios plus random
// jobs, compared every cycle against an edge-timed behavioural model.
module tb_result_requant_wb;

  localparam int MS = 32;
  localparam int PB = 24;
  localparam int DB = 8;
  localparam int AW = 10;
  localparam int CW = MS * DB;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [6:0]        num_vec;
  logic [4:0]        shift;
  logic              relu_en;
  logic              in_valid;
  logic [MS*PB-1:0]  in_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [MS*DB-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              overrun;

  result_requant_wb dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .num_vec   (num_vec),
    .shift     (shift),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state, expressed as edge numbers of expected events.
  int  ecount;
  int  m_start_e;
  int  m_done_e;
  bit  m_acc_open;
  int  m_cnt;
  int  m_nv;
  int  m_sh;
  bit  m_relu;
  int  m_base;
  bit  m_ovr;
  logic [AW-1:0]    exp_addr_q [int];
  logic [MS*DB-1:0] exp_data_q [int];

  logic [AW-1:0]    wr_seen [$];
  logic [MS*DB-1:0] last_data;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rq_lane(input int x, input int sh, input bit relu);
    longint r;
    longint s;
    r = (relu && x < 0) ? 64'sd0 : longint'(x);
    s = r + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    s = s >>> sh;
    if (s > 127) return 127;
    if (s < -128) return -128;
    return int'(s);
  endfunction

  function automatic logic [MS*DB-1:0] rq_vec(input logic [MS*PB-1:0] v, input int sh, input bit relu);
    logic [MS*DB-1:0] o;
    int x;
    int t;
    o = '0;
    for (int i = 0; i < MS; i++) begin
      x = $signed(v[i*PB +: PB]);
      t = rq_lane(x, sh, relu);
      o[i*DB +: DB] = t[DB-1:0];
    end
    return o;
  endfunction

  function automatic logic [MS*PB-1:0] rand_vec(input bit wide);
    logic [MS*PB-1:0] v;
    int t;
    for (int i = 0; i < MS; i++) begin
      if (wide) t = int'($urandom);
      else      t = int'($urandom_range(4000)) - 2000;
      v[i*PB +: PB] = t[PB-1:0];
    end
    return v;
  endfunction

  // Apply the current inputs to the model for the edge about to happen.
  task automatic model_edge();
    int e;
    bit idle_now;
    bit launched;
    e = ecount + 1;
    launched = 1'b0;
    if (rstn) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      m_acc_open = 1'b0;
      m_start_e  = -10;
      m_done_e   = -10;
      m_ovr      = 1'b0;
    end else begin
      idle_now = !m_acc_open && (e >= m_done_e + 2);
      if (start && idle_now) begin
        m_base = int'(base_addr);
        m_nv   = int'(num_vec);
        m_sh   = int'(shift);
        m_relu = relu_en;
        m_cnt  = 0;
        m_ovr  = 1'b0;
        m_start_e = e;
        launched = 1'b1;
        if (m_nv == 0) begin
          m_acc_open = 1'b0;
          m_done_e   = e;
        end else begin
          m_acc_open = 1'b1;
          m_done_e   = 1 << 30;
        end
      end
      if (in_valid) begin
        if (m_acc_open && !launched) begin
          exp_addr_q[e+2] = AW'(m_base + m_cnt);
          exp_data_q[e+2] = rq_vec(in_data, m_sh, m_relu);
          m_cnt++;
          if (m_cnt == m_nv) begin
            m_acc_open = 1'b0;
            m_done_e   = e + 3;
          end
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    ecount = e;
  endtask

  task automatic check_outputs();
    int  e;
    bit  exp_en;
    e = ecount;
    exp_en = exp_addr_q.exists(e);
    chk("wr_en", CW'(wr_en), CW'(exp_en));
    chk("wr_addr", CW'(wr_addr), exp_en ? CW'(exp_addr_q[e]) : '0);
    chk("wr_data", wr_data, exp_en ? exp_data_q[e] : '0);
    chk("done", CW'(done), CW'(e == m_done_e));
    chk("busy", CW'(busy), CW'((e >= m_start_e) && (e <= m_done_e)));
    chk("overrun", CW'(overrun), CW'(m_ovr));
    if (wr_en === 1'b1) begin
      wr_seen.push_back(wr_addr);
      last_data = wr_data;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [6:0] nv, input logic [4:0] sh, input logic rl);
    base_addr = b; num_vec = nv; shift = sh; relu_en = rl;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [MS*PB-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      cyc();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $error("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
    cyc();
  endtask

  initial begin
    logic [MS*PB-1:0] v;
    int               rexp [5];
    int               rin  [5];
    int               t;
    logic [AW-1:0]    wexp [4];
    int               nv;

    ecount = 0; m_start_e = -10; m_done_e = -10; m_acc_open = 1'b0; m_ovr = 1'b0;
    m_cnt = 0; m_nv = 0; m_sh = 0; m_relu = 1'b0; m_base = 0;
    last_data = '0;
    rstn = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; shift = '0;
    relu_en = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state.
    cyc(); cyc();
    rstn = 1'b0;
    cyc();

    // Basic job: four vectors of 256, shift 4 -> 0x10 in every lane.
    wr_seen.delete();
    do_start(10'h010, 7'd4, 5'd4, 1'b0);
    for (int i = 0; i < MS; i++) v[i*PB +: PB] = 24'h000100;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = v; cyc();
    end
    in_valid = 1'b0;
    wait_idle();
    chk("basic_count", CW'(wr_seen.size()), CW'(4));
    if (wr_seen.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("basic_addr", CW'(wr_seen[k]), CW'(10'h010 + k));
    end
    chk("basic_data", last_data, {MS{8'h10}});

    // Rounding, saturation and ReLU on a fixed lane pattern.
    rin = '{24, -24, 5000, -5000, -1};
    for (int i = 0; i < MS; i++) begin
      t = rin[i % 5];
      v[i*PB +: PB] = t[PB-1:0];
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 0) rexp = '{2, -1, 127, -128, 0};
      else        rexp = '{2, 0, 127, 0, 0};
      do_start(10'h020, 7'd1, 5'd4, r[0]);
      send_vec(v);
      wait_idle();
      for (int i = 0; i < 5; i++) begin
        t = rexp[i];
        chk("round_lane", CW'(last_data[i*DB +: DB]), CW'(t[DB-1:0]));
      end
    end

    // Address wrap-around.
    wr_seen.delete();
    do_start(10'h3FE, 7'd4, 5'($urandom_range(23)), 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_vec(rand_vec(1'b0));
      if (k == 1) cyc();
    end
    wait_idle();
    wexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    chk("wrap_count", CW'(wr_seen.size()), CW'(4));
    if (wr_seen.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("wrap_addr", CW'(wr_seen[k]), CW'(wexp[k]));
    end

    // Zero-length job.
    wr_seen.delete();
    do_start(10'h0AA, 7'd0, 5'd3, 1'b0);
    cyc(); cyc();
    wait_idle();
    chk("zero_nowrite", CW'(wr_seen.size()), CW'(0));

    // Start pulsed during RUN is ignored.
    wr_seen.delete();
    do_start(10'h100, 7'd3, 5'd2, 1'b1);
    send_vec(rand_vec(1'b0));
    do_start(10'h200, 7'd1, 5'd0, 1'b0);
    send_vec(rand_vec(1'b0));
    send_vec(rand_vec(1'b0));
    wait_idle();
    chk("restart_count", CW'(wr_seen.size()), CW'(3));
    if (wr_seen.size() == 3) chk("restart_addr", CW'(wr_seen[2]), CW'(10'h102));

    // Overrun from in_valid while idle; cleared by the next start.
    wr_seen.delete();
    send_vec(rand_vec(1'b1));
    cyc(); cyc();
    chk("ovr_set", CW'(overrun), CW'(1));
    chk("ovr_nowrite", CW'(wr_seen.size()), CW'(0));
    do_start(10'h040, 7'd1, 5'd1, 1'b0);
    chk("ovr_clear", CW'(overrun), CW'(0));
    send_vec(rand_vec(1'b0));
    wait_idle();

    // Reset in the middle of an 8-vector job, then a normal job.
    wr_seen.delete();
    do_start(10'h050, 7'd8, 5'd3, 1'b0);
    in_valid = 1'b1; in_data = rand_vec(1'b0); cyc();
    in_data = rand_vec(1'b0); cyc();
    in_valid = 1'b0;
    rstn = 1'b1; cyc();
    rstn = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    chk("rst_nowrite", CW'(wr_seen.size()), CW'(0));
    do_start(10'h060, 7'd5, 5'd5, 1'b1);
    for (int k = 0; k < 5; k++) send_vec(rand_vec(1'b0));
    wait_idle();
    chk("rst_after_count", CW'(wr_seen.size()), CW'(5));

    // Random jobs with random gaps, including back-to-back bursts.
    for (int j = 0; j < 8; j++) begin
      nv = int'($urandom_range(20, 1));
      do_start(AW'($urandom), 7'(nv), 5'($urandom_range(23)), 1'($urandom_range(1)));
      for (int k = 0; k < nv; k++) begin
        while ($urandom_range(3) == 0) cyc();
        in_valid = 1'b1;
        in_data  = rand_vec(1'($urandom_range(1)));
        cyc();
      end
      in_valid = 1'b0;
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_requant_wb.md
RESULT_REQUANT_WB -- requirements
Module: result_requant_wb

Interface
REQ-001 Parameter MATRIX_SIZE, default 32, number of result lanes per vector.
REQ-002 Parameter PARTIAL_SUM_BW, default 24, signed width of each input lane.
REQ-003 Parameter DATA_BW, default 8, signed width of each output lane.
REQ-004 Parameter ADDRESSSIZE, default 10, unified-buffer address width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rstn  input  1  synchronous, active-high reset: 1 = reset, sampled on rising clk.
REQ-007 start  input  1  one-cycle pulse that launches a writeback job.
REQ-008 base_addr  input  ADDRESSSIZE  first unified-buffer write address; latched on accepted start.
REQ-009 num_vec  input  7  number of vectors in the job (0..64); latched on accepted start.
REQ-010 shift  input  5  arithmetic right-shift amount (0..23); latched on accepted start.
REQ-011 relu_en  input  1  clamp negative sums to 0 before shifting; latched on accepted start.
REQ-012 in_valid  input  1  in_data holds one result vector this cycle; there is no backpressure.
REQ-013 in_data  input  PARTIAL_SUM_BW*MATRIX_SIZE  lane i at bits [24i+23:24i], signed.
REQ-014 wr_en  output  1  unified-buffer write strobe.
REQ-015 wr_addr  output  ADDRESSSIZE  write address.
REQ-016 wr_data  output  DATA_BW*MATRIX_SIZE  lane i at bits [8i+7:8i].
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 overrun  output  1  sticky flag: an in_valid arrived outside RUN.

Function
REQ-020 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-021 IDLE + start: latch the configuration, clear overrun, clear in_cnt; go to RUN, or to DONE if num_vec = 0.
REQ-022 start outside IDLE is ignored; the latched configuration is unchanged.
REQ-023 RUN: each in_valid is accepted and increments in_cnt; the accept that makes in_cnt equal num_vec moves the FSM to FLUSH.
REQ-024 FLUSH: stay until the pipeline holds no valid entry, then go to DONE.
REQ-025 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-026 in_valid in IDLE, FLUSH or DONE is dropped (no write) and sets overrun.
REQ-027 Pipeline is 2 stages.
  - Stage 1: ReLU, add rounding offset, arithmetic shift.
  - Stage 2: saturate, pack, register.
  - Latency: an accepted vector at edge t produces wr_en high during the cycle after edge t+2.
REQ-028 Per-lane arithmetic, with x the signed PARTIAL_SUM_BW input:
  - r = (relu_en && x<0) ? 0 : x.
  - y = (r + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed at PARTIAL_SUM_BW+1 bits so it never overflows.
  - Output = y clamped to [-128, 127].
REQ-029 The k-th accepted vector of a job (k = 0..num_vec-1) is written to wr_addr = (base_addr + k) mod 2^ADDRESSSIZE; wrap-around is allowed.
REQ-030 Back-to-back in_valid every cycle is sustained with one write per cycle and no bubbles.
REQ-031 wr_addr and wr_data are 0 whenever wr_en = 0.
REQ-032 Exactly num_vec writes occur per job; done follows the cycle of the last write.

Reset
REQ-033 rstn = 1 at any edge forces:
  - state IDLE, pipeline valid bits cleared, in_cnt 0;
  - outputs wr_en, wr_addr, wr_data, busy, done and overrun all 0.
REQ-034 Reset mid-job aborts the job: in-flight writes are discarded and no done is issued.

Structure
REQ-035 A shared package holds:
  - the FSM state enum;
  - constants for the lane count, PARTIAL_SUM_BW, DATA_BW, saturation limits (127, -128) and maximum job length (64).
REQ-036 A single sub-module, requant_lane (ReLU/round/shift/saturate for one lane), is instantiated MATRIX_SIZE times; the FSM, counters and address generation stay in result_requant_wb.

Verification
REQ-037 Basic job:
  - Stimulus: start with base=0x010, num_vec=4, shift=4, relu_en=0; 4 consecutive vectors, all lanes = 0x000100 (256).
  - Response: writes at 0x010..0x013, every lane 0x10; done 1 cycle after the last write.
REQ-038 Rounding, saturation and ReLU:
  - Stimulus: lanes = 24, -24, 5000, -5000, -1; shift=4.
  - relu_en=0 response: 2, -1, 127, -128, 0 (i.e. (-1+8)>>>4).
  - relu_en=1 response: 2, 0, 127, 0, 0.
REQ-039 Address wrap:
  - Stimulus: base=0x3FE, num_vec=4.
  - Response: wr_addr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-040 Zero-length job and ignored restart:
  - num_vec=0: done within 2 cycles of start, no wr_en.
  - start pulsed during RUN: no effect on the running job.
REQ-041 Overrun:
  - Stimulus: in_valid in IDLE.
  - Response: no write, overrun=1 until the next accepted start clears it.
REQ-042 Reset mid-job:
  - Stimulus: rstn=1 for one edge after 2 of 8 vectors.
  - Response: all outputs 0, no further writes, no done; a new job then runs normally.
